// File: rtl/chia_xung_pwm_if.sv
// Control/status bundle for chia_xung_pwm.
// master: the block that programs the divider and watches its outputs.
// slave:  the divider itself.
interface chia_xung_pwm_if #(
    parameter int unsigned W = 8
);
    logic         en;
    logic         mode;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         cd;
    logic         wrap;
    logic [W-1:0] cnt;
    logic         busy;

    modport master (
        output en, mode, period, duty,
        input  cd, wrap, cnt, busy
    );

    modport slave (
        input  en, mode, period, duty,
        output cd, wrap, cnt, busy
    );
endinterface

// File: rtl/chia_xung_pwm.sv
// Pulse-counting divider / PWM generator.
// The raw pulse p is synchronised, optionally glitch-filtered, and edge-detected into a
// registered 1-clock tick. The counter runs 0..per_sh on ticks; cd is high while the count is
// above dut_sh. Shadow registers reload only on IDLE->RUN and at each wrap.
// Build option: define CHIA_XUNG_FILTER_EN to insert a FILT_LEN-clock stability filter
// between the synchroniser and the edge detector.
module chia_xung_pwm #(
    parameter int unsigned W        = 8,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p,
    chia_xung_pwm_if.slave    bus
);

    if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_filt_len_chk
        $error("chia_xung_pwm: FILT_LEN must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_sh_q, per_sh_d;
    logic [W-1:0] dut_sh_q, dut_sh_d;
    logic         wrap_q, wrap_d;

    logic         sync1_q, sync1_d;
    logic         sync2_q, sync2_d;
    logic [1:0]   vld_q, vld_d;     // marks sync stages holding post-reset samples
    logic         armed_q, armed_d; // set once a genuine low level has been seen
    logic         prev_q, prev_d;
    logic         tick_q, tick_d;
    logic         lvl;

`ifdef CHIA_XUNG_FILTER_EN
    logic         filt_q, filt_d;
    logic [7:0]   fcnt_q, fcnt_d;

    // Filtered level follows sync2 only after it differs for FILT_LEN consecutive clocks.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 8'd0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == 8'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // Filter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= 8'd0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    // Synchroniser, arming and rising-edge detection; a level already high out of reset
    // never counts as an edge because armed stays clear until a real low is sampled.
    always_comb begin
        sync1_d = p;
        sync2_d = sync1_q;
        vld_d   = {vld_q[0], 1'b1};
        armed_d = armed_q | (vld_q[1] & ~sync2_q);
        prev_d  = lvl;
        tick_d  = lvl & ~prev_q & armed_q;
    end

    // Front-end registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    // FSM next state, counter, shadow reload and wrap strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_sh_d = per_sh_q;
        dut_sh_d = dut_sh_q;
        wrap_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A tick landing on this clock is deliberately dropped.
                if (bus.en) begin
                    state_d  = StRun;
                    per_sh_d = bus.period;
                    dut_sh_d = bus.duty;
                end
            end
            StRun: begin
                if (!bus.en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tick_q) begin
                    if (cnt_q == per_sh_q) begin
                        cnt_d    = '0;
                        wrap_d   = 1'b1;
                        per_sh_d = bus.period;
                        dut_sh_d = bus.duty;
                        if (bus.mode) begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
            end
            StDone: begin
                cnt_d = '0;
                if (!bus.en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            per_sh_q <= '0;
            dut_sh_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_sh_q <= per_sh_d;
            dut_sh_q <= dut_sh_d;
            wrap_q   <= wrap_d;
        end
    end

    // Outputs decode registered state only.
    assign bus.cnt  = cnt_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = (state_q == StRun);
    assign bus.cd   = (state_q == StRun) && (cnt_q > dut_sh_q);

endmodule

// File: tb/tb_chia_xung_pwm.sv
// Directed bench for chia_xung_pwm. Each tick pushes its expected outcome to a scoreboard
// queue; the entry is popped and compared when the counter should have reacted.
module tb_chia_xung_pwm;

    localparam int FL = 4;
`ifdef CHIA_XUNG_FILTER_EN
    localparam int LAT  = 3 + FL;
    localparam int LOWT = FL + 3;
`else
    localparam int LAT  = 3;
    localparam int LOWT = 2;
`endif

    typedef struct {
        string      tag;
        logic [7:0] cnt;
        logic       wrap;
        logic       cd;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    logic clk;
    logic rst_n;
    logic p;
    int   checks;
    int   errors;
    int   wrap_cnt;
    int   cd_hi;

    chia_xung_pwm_if #(.W(8)) bus ();

    chia_xung_pwm #(.W(8), .FILT_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p     (p),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wrap === 1'b1) wrap_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One p pulse; counter must be unchanged one clock before the expected reaction.
    task automatic tick(input string tag, input logic [7:0] c, input logic w, input logic d,
                        input logic b, input logic en_rise);
        exp_t       e;
        logic [7:0] pre;
        sb.push_back('{tag, c, w, d, b});
        @(negedge clk);
        p = 1'b1;
        @(posedge clk);
        #1 pre = bus.cnt;
        repeat (LAT - 1) @(posedge clk);
        #1 chk({tag, "_early"}, 32'(bus.cnt), 32'(pre));
        if (en_rise) begin
            @(negedge clk);
            bus.en = 1'b1;
        end
        @(posedge clk);
        #1 e = sb.pop_front();
        chk({e.tag, "_cnt"}, 32'(bus.cnt), 32'(e.cnt));
        chk({e.tag, "_wrap"}, 32'(bus.wrap), 32'(e.wrap));
        chk({e.tag, "_cd"}, 32'(bus.cd), 32'(e.cd));
        chk({e.tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
        if (bus.cd === 1'b1) cd_hi++;
        @(negedge clk);
        p = 1'b0;
        repeat (LOWT) @(negedge clk);
    endtask

    // Drop to IDLE, program new settings, then start running.
    task automatic restart(input logic [7:0] per, input logic [7:0] dut, input logic md);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk("restart_idle_busy", 32'(bus.busy), 32'd0);
        chk("restart_idle_cnt", 32'(bus.cnt), 32'd0);
        bus.period = per;
        bus.duty   = dut;
        bus.mode   = md;
        bus.en     = 1'b1;
        @(posedge clk);
        #1 chk("restart_run_busy", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        int w0;
        checks     = 0;
        errors     = 0;
        wrap_cnt   = 0;
        cd_hi      = 0;
        rst_n      = 1'b0;
        p          = 1'b0;
        bus.en     = 1'b0;
        bus.mode   = 1'b0;
        bus.period = 8'd0;
        bus.duty   = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(bus.cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cd", 32'(bus.cd), 32'd0);
        chk("rst_wrap", 32'(bus.wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Continuous: period 100, duty 50, 202 ticks -> 2 wraps, cd high 100 ticks
        restart(8'd100, 8'd50, 1'b0);
        w0    = wrap_cnt;
        cd_hi = 0;
        for (int i = 0; i < 202; i++) begin
            int c;
            c = (i + 1) % 101;
            tick("cont", 8'(c), (c == 0), (c > 50), 1'b1, 1'b0);
        end
        chk("cont_wraps", 32'(wrap_cnt - w0), 32'd2);
        chk("cont_cd_ticks", 32'(cd_hi), 32'd100);

        // Shadow reload: change settings at cnt 6, takes effect after the wrap at 10
        restart(8'd10, 8'd4, 1'b0);
        for (int i = 1; i <= 6; i++) tick("shd_a", 8'(i), 1'b0, (i > 4), 1'b1, 1'b0);
        bus.period = 8'd5;
        bus.duty   = 8'd2;
        for (int i = 7; i <= 10; i++) tick("shd_b", 8'(i), 1'b0, 1'b1, 1'b1, 1'b0);
        tick("shd_wrap10", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) tick("shd_c", 8'(i), 1'b0, (i > 2), 1'b1, 1'b0);
        tick("shd_wrap5", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // One-shot: period 3, duty 1, 8 ticks -> one wrap, then DONE
        restart(8'd3, 8'd1, 1'b1);
        w0 = wrap_cnt;
        tick("os1", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("os2", 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("os3", 8'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("os4", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i <= 8; i++) tick("os_done", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("os_wraps", 32'(wrap_cnt - w0), 32'd1);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1 chk("os_rerun_busy", 32'(bus.busy), 32'd1);
        tick("os_rerun", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Abort with en=0 at cnt 7
        restart(8'd20, 8'd5, 1'b0);
        for (int i = 1; i <= 7; i++) tick("abort_cnt", 8'(i), 1'b0, (i > 5), 1'b1, 1'b0);
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_cnt0", 32'(bus.cnt), 32'd0);
        chk("abort_cd", 32'(bus.cd), 32'd0);
        chk("abort_wrap", 32'(bus.wrap), 32'd0);

        // Reset at cnt 7, p held high across release
        restart(8'd20, 8'd5, 1'b0);
        for (int i = 1; i <= 7; i++) tick("rsta_cnt", 8'(i), 1'b0, (i > 5), 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rsta_busy", 32'(bus.busy), 32'd0);
        chk("rsta_cnt0", 32'(bus.cnt), 32'd0);
        chk("rsta_cd", 32'(bus.cd), 32'd0);
        chk("rsta_wrap", 32'(bus.wrap), 32'd0);
        @(negedge clk);
        p = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        chk("rsta_p_high_busy", 32'(bus.busy), 32'd1);
        chk("rsta_p_high_no_tick", 32'(bus.cnt), 32'd0);
        p = 1'b0;
        repeat (LOWT) @(negedge clk);
        tick("rsta_fresh", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);

        // period 0: every tick wraps, cd stays 0
        restart(8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick("per0", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // duty == period: cd never high
        restart(8'd20, 8'd20, 1'b0);
        for (int i = 1; i <= 21; i++) begin
            tick("dut_eq_per", 8'(i % 21), (i == 21), 1'b0, 1'b1, 1'b0);
        end

        // Tick on the same clock as IDLE->RUN is ignored
        @(negedge clk);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        tick("coinc", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("coinc_next", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef CHIA_XUNG_FILTER_EN
        // 2-clock glitch is swallowed by the filter
        begin
            logic [7:0] pre;
            pre = bus.cnt;
            @(negedge clk);
            p = 1'b1;
            repeat (2) @(negedge clk);
            p = 1'b0;
            repeat (15) @(negedge clk);
            chk("filt_glitch", 32'(bus.cnt), 32'(pre));
            tick("filt_pulse", 8'(pre + 8'd1), 1'b0, 1'b0, 1'b1, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
